// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//
// Parametrised serial-bit sequence detector. Each qualified input bit is
// shifted into a history window. When the window holds PATTERN (MSB = the
// oldest bit) and enough bits have been seen since the last reset/clear/
// non-overlapping match, a registered one-cycle match pulse is produced and
// a saturating match counter advances.
//
// Parameters
//   PAT_W    pattern length in bits (2..16)
//   PATTERN  target pattern, MSB is the first-received bit
//   OVERLAP  1: history kept after a match (overlapping matches)
//            0: history discarded after a match
//   CNT_W    width of the saturating match counter
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in           serial data bit
//   in_valid     qualifies in; the bit is sampled only when high
//   clear        synchronous clear of history, fill, counter and out
//   out          match pulse, high for one cycle after the completing bit
//   match_count  saturating count of matches
//   fill         number of valid bits currently held in the history
// -----------------------------------------------------------------------------
module seq_detect_param #(
    parameter int                PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PATTERN = 4'b1111,
    parameter bit                OVERLAP = 1'b1,
    parameter int                CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in,
    input  logic                         in_valid,
    input  logic                         clear,
    output logic                         out,
    output logic [CNT_W-1:0]             match_count,
    output logic [$clog2(PAT_W+1)-1:0]   fill
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    // Fill level at which the incoming bit can complete a full window.
    localparam logic [FILL_W-1:0] FILL_MATCH_MIN = FILL_W'(PAT_W - 1);
    localparam logic [FILL_W-1:0] FILL_MAX       = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX        = {CNT_W{1'b1}};

    // Only the newest PAT_W-1 bits are stored: the oldest bit of a full
    // window is shifted out by the very bit that is compared against it, so
    // it never takes part in a later comparison.
    logic [PAT_W-2:0]  hist_reg;
    logic [PAT_W-2:0]  hist_next;
    logic [FILL_W-1:0] fill_reg;
    logic [FILL_W-1:0] fill_next;
    logic              out_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;

    // Window as it would look after accepting the current bit.
    logic [PAT_W-1:0]  new_hist;
    logic [PAT_W-1:0]  bit_eq;
    logic              pattern_hit;
    logic              window_full;
    logic              match;

    assign new_hist = {hist_reg, in};

    // Bitwise pattern comparison, reduced below.
    genvar gi;
    generate
        for (gi = 0; gi < PAT_W; gi++) begin : g_cmp
            assign bit_eq[gi] = (new_hist[gi] == PATTERN[gi]);
        end
    endgenerate

    assign pattern_hit = &bit_eq;

    // Guarantees that bits from before a reset/clear (held as zeros in the
    // history) can never make up part of a match.
    assign window_full = (fill_reg >= FILL_MATCH_MIN);

    assign match = in_valid && window_full && pattern_hit;

    always_comb begin
        hist_next  = hist_reg;
        fill_next  = fill_reg;
        count_next = count_reg;

        if (in_valid) begin
            if (match) begin
                if (OVERLAP) begin
                    hist_next = new_hist[PAT_W-2:0];
                    fill_next = FILL_MAX;
                end else begin
                    hist_next = '0;
                    fill_next = '0;
                end
                if (count_reg != CNT_MAX) begin
                    count_next = count_reg + 1'b1;
                end
            end else begin
                hist_next = new_hist[PAT_W-2:0];
                if (fill_reg != FILL_MAX) begin
                    fill_next = fill_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_reg  <= '0;
            fill_reg  <= '0;
            out_reg   <= 1'b0;
            count_reg <= '0;
        end else if (clear) begin
            hist_reg  <= '0;
            fill_reg  <= '0;
            out_reg   <= 1'b0;
            count_reg <= '0;
        end else begin
            hist_reg  <= hist_next;
            fill_reg  <= fill_next;
            // match already includes in_valid, so out drops on idle cycles.
            out_reg   <= match;
            count_reg <= count_next;
        end
    end

    assign out         = out_reg;
    assign match_count = count_reg;
    assign fill        = fill_reg;

endmodule

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param
//
// Six detector configurations share one stimulus stream. A behavioural model
// keeps, per configuration, the list of bits received since the last flush and
// decides matches by comparing the newest PAT_W bits against the pattern
// value. Expected outputs are queued with the cycle they become visible; a
// monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;

    localparam int ND = 6;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic in       = 1'b0;
    logic in_valid = 1'b0;
    logic clear    = 1'b0;

    always #10 clk = ~clk;

    logic       out0, out1, out2, out3, out4, out5;
    logic [7:0] cnt0, cnt1, cnt2, cnt3;
    logic [1:0] cnt4;
    logic [3:0] cnt5;
    logic [2:0] fill0, fill1, fill2, fill3, fill4;
    logic [1:0] fill5;

    seq_detect_param u0 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clear(clear),
        .out(out0), .match_count(cnt0), .fill(fill0));

    seq_detect_param #(.OVERLAP(1'b0)) u1 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clear(clear),
        .out(out1), .match_count(cnt1), .fill(fill1));

    seq_detect_param #(.PATTERN(4'b1011)) u2 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clear(clear),
        .out(out2), .match_count(cnt2), .fill(fill2));

    seq_detect_param #(.PATTERN(4'b1011), .OVERLAP(1'b0)) u3 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clear(clear),
        .out(out3), .match_count(cnt3), .fill(fill3));

    seq_detect_param #(.CNT_W(2)) u4 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clear(clear),
        .out(out4), .match_count(cnt4), .fill(fill4));

    seq_detect_param #(.PAT_W(2), .PATTERN(2'b01), .OVERLAP(1'b0), .CNT_W(4)) u5 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clear(clear),
        .out(out5), .match_count(cnt5), .fill(fill5));

    bit out_a  [ND];
    int cnt_a  [ND];
    int fill_a [ND];

    always_comb begin
        out_a[0] = out0;  cnt_a[0] = int'(cnt0);  fill_a[0] = int'(fill0);
        out_a[1] = out1;  cnt_a[1] = int'(cnt1);  fill_a[1] = int'(fill1);
        out_a[2] = out2;  cnt_a[2] = int'(cnt2);  fill_a[2] = int'(fill2);
        out_a[3] = out3;  cnt_a[3] = int'(cnt3);  fill_a[3] = int'(fill3);
        out_a[4] = out4;  cnt_a[4] = int'(cnt4);  fill_a[4] = int'(fill4);
        out_a[5] = out5;  cnt_a[5] = int'(cnt5);  fill_a[5] = int'(fill5);
    end

    // Model configuration, one entry per instance above.
    int mw   [ND] = '{4, 4, 4, 4, 4, 2};
    int mpat [ND] = '{15, 15, 11, 11, 15, 1};
    bit movl [ND] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int mmax [ND] = '{255, 255, 255, 255, 3, 15};

    int mcnt [ND];
    bit mq   [ND][$];

    typedef struct {
        int due;
        int dut;
        bit o;
        int c;
        int f;
    } exp_t;

    exp_t sbq[$];

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int dut, input int act, input int expv);
        n_checks++;
        if (act == expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, dut, cyc, act, expv);
        end
    endtask

    // Monitor: compare every expectation that has become visible.
    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            check("out",   e.dut, int'(out_a[e.dut]), int'(e.o));
            check("count", e.dut, cnt_a[e.dut],       e.c);
            check("fill",  e.dut, fill_a[e.dut],      e.f);
        end
    end

    function automatic int window_value(input int k);
        int v = 0;
        foreach (mq[k][i]) v = (v << 1) | int'(mq[k][i]);
        return v;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < ND; k++) begin
            mq[k].delete();
            mcnt[k] = 0;
        end
    endfunction

    // Drive one cycle of stimulus and queue the resulting expectations.
    task automatic step(input bit b, input bit v, input bit c);
        exp_t e;
        bit   hit;
        @(negedge clk);
        in       = b;
        in_valid = v;
        clear    = c;
        for (int k = 0; k < ND; k++) begin
            hit = 1'b0;
            if (c) begin
                mq[k].delete();
                mcnt[k] = 0;
            end else if (v) begin
                mq[k].push_back(b);
                if (mq[k].size() > mw[k]) void'(mq[k].pop_front());
                hit = (mq[k].size() == mw[k]) && (window_value(k) == mpat[k]);
                if (hit) begin
                    if (!movl[k]) mq[k].delete();
                    if (mcnt[k] < mmax[k]) mcnt[k]++;
                end
            end
            e.due = cyc + 1;
            e.dut = k;
            e.o   = hit;
            e.c   = mcnt[k];
            e.f   = mq[k].size();
            sbq.push_back(e);
        end
    endtask

    task automatic ones(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0);
    endtask

    // Reset pulse placed between clock edges; outputs must clear at once.
    task automatic async_reset();
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        rst      = 1'b1;
        #2;
        for (int k = 0; k < ND; k++) begin
            check("rst_out",   k, int'(out_a[k]), 0);
            check("rst_count", k, cnt_a[k],       0);
            check("rst_fill",  k, fill_a[k],      0);
        end
        #3;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bit b, v, c;
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Overlapping run on the default pattern.
        step(1'b0, 1'b1, 1'b0);
        ones(5);

        // Asynchronous reset with nonzero state.
        async_reset();

        // Eight ones: non-overlap variant pulses after bits 4 and 8.
        step(1'b0, 1'b0, 1'b1);
        ones(8);

        // 1011 in both modes.
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        // Gap with toggling data is transparent.
        step(1'b0, 1'b0, 1'b1);
        ones(2);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        ones(2);
        step(1'b0, 1'b0, 1'b0);

        // Counter saturation, then clear with a bit presented alongside.
        step(1'b0, 1'b0, 1'b1);
        ones(20);
        step(1'b1, 1'b1, 1'b1);
        ones(3);
        ones(1);

        // Reset after three ones loses the partial match.
        step(1'b0, 1'b0, 1'b1);
        ones(3);
        async_reset();
        ones(1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset();
            end else begin
                b = 1'($urandom_range(0, 1));
                v = ($urandom_range(0, 3) != 0);
                c = ($urandom_range(0, 59) == 0);
                step(b, v, c);
            end
        end

        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("drain", 0, sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
